// File: rtl/ddr_cmd_arb.sv
// ddr_cmd_arb: owner of the DDR command bus.
//   After reset the init sequencer's command bus is passed straight through.
//   Once init_done is seen, user commands are arbitrated against an internal
//   periodic auto-refresh scheduler. Each refresh is issued as PRECHARGE-ALL,
//   then TRP_CYC NOPs, then AUTO REFRESH, then TRFC_CYC NOPs.
//   All ddr_* outputs are registered: the command chosen in cycle N is driven
//   in cycle N+1.
//
// Ports:
//   core_clk, core_rst_sync        clock, async active-high reset
//   init_done                      init sequencer finished (sampled in INIT_PASS only)
//   init_cs_n..init_we_n, init_ba, init_a   init command bus
//   usr_req, usr_ras_n..usr_we_n, usr_ba, usr_a   user command, held until usr_ack
//   usr_ack                        user command accepted this cycle (combinational)
//   ref_busy                       refresh sequence in progress
//   ref_overflow                   sticky, a refresh demand was lost at saturation
//   ddr_cs_n..ddr_we_n, ddr_ba, ddr_a   registered DDR command outputs
module ddr_cmd_arb #(
  parameter int BA_BITS   = 2,
  parameter int ROW_BITS  = 13,
  parameter int TREFI_CYC = 780,
  parameter int TRP_CYC   = 3,
  parameter int TRFC_CYC  = 10,
  parameter int MAX_PEND  = 8
) (
  input  logic                core_clk,
  input  logic                core_rst_sync,
  input  logic                init_done,
  input  logic                init_cs_n,
  input  logic                init_ras_n,
  input  logic                init_cas_n,
  input  logic                init_we_n,
  input  logic [BA_BITS-1:0]  init_ba,
  input  logic [ROW_BITS-1:0] init_a,
  input  logic                usr_req,
  input  logic                usr_ras_n,
  input  logic                usr_cas_n,
  input  logic                usr_we_n,
  input  logic [BA_BITS-1:0]  usr_ba,
  input  logic [ROW_BITS-1:0] usr_a,
  output logic                usr_ack,
  output logic                ref_busy,
  output logic                ref_overflow,
  output logic                ddr_cs_n,
  output logic                ddr_ras_n,
  output logic                ddr_cas_n,
  output logic                ddr_we_n,
  output logic [BA_BITS-1:0]  ddr_ba,
  output logic [ROW_BITS-1:0] ddr_a
);

  localparam int TW   = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
  localparam int PW   = $clog2(MAX_PEND + 1);
  localparam int WMAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int WW   = (WMAX > 1) ? $clog2(WMAX) : 1;

  typedef enum logic [2:0] {
    INIT_PASS, IDLE, PREA, PREA_WAIT, REF, REF_WAIT
  } state_t;

  typedef struct packed {
    logic                cs_n;
    logic                ras_n;
    logic                cas_n;
    logic                we_n;
    logic [BA_BITS-1:0]  ba;
    logic [ROW_BITS-1:0] a;
  } cmd_t;

  state_t          r_state, w_nxt;
  cmd_t            r_cmd, w_cmd;
  logic [TW-1:0]   r_timer;
  logic [PW-1:0]   r_ref_pend;
  logic [WW-1:0]   r_wait;
  logic            r_ovf;
  logic            w_wrap, w_dec, w_force, w_ack;

  assign w_wrap  = (r_state != INIT_PASS) && (r_timer == TW'(TREFI_CYC - 1));
  assign w_dec   = (r_state == REF);
  assign w_force = (r_ref_pend == PW'(MAX_PEND));

  // Next state and the command to register for the next cycle.
  always_comb begin
    w_nxt = r_state;
    w_ack = 1'b0;
    w_cmd = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, ba: '0, a: '0};
    case (r_state)
      INIT_PASS: begin
        w_cmd = '{cs_n: init_cs_n, ras_n: init_ras_n, cas_n: init_cas_n,
                  we_n: init_we_n, ba: init_ba, a: init_a};
        if (init_done) w_nxt = IDLE;
      end
      IDLE: begin
        // Refresh wins when forced, or opportunistically when the user is quiet.
        if (w_force || (r_ref_pend != '0 && !usr_req)) begin
          w_nxt = PREA;
        end else if (usr_req) begin
          w_ack = 1'b1;
          w_cmd = '{cs_n: 1'b0, ras_n: usr_ras_n, cas_n: usr_cas_n,
                    we_n: usr_we_n, ba: usr_ba, a: usr_a};
        end
      end
      PREA: begin
        w_cmd.ras_n = 1'b0;
        w_cmd.we_n  = 1'b0;
        w_cmd.a[10] = 1'b1;  // all banks
        w_nxt       = PREA_WAIT;
      end
      PREA_WAIT: if (r_wait == WW'(TRP_CYC - 1)) w_nxt = REF;
      REF: begin
        w_cmd.ras_n = 1'b0;
        w_cmd.cas_n = 1'b0;
        w_nxt       = REF_WAIT;
      end
      REF_WAIT: if (r_wait == WW'(TRFC_CYC - 1)) w_nxt = IDLE;
      default: w_nxt = INIT_PASS;
    endcase
  end

  always_ff @(posedge core_clk or posedge core_rst_sync) begin
    if (core_rst_sync) begin
      r_state <= INIT_PASS;
      r_cmd   <= '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1, ba: '0, a: '0};
      r_wait  <= '0;
    end else begin
      r_state <= w_nxt;
      r_cmd   <= w_cmd;
      // NOP spacing counter: runs only while parked in a wait state.
      if ((r_state == PREA_WAIT || r_state == REF_WAIT) && w_nxt == r_state)
        r_wait <= r_wait + WW'(1);
      else
        r_wait <= '0;
    end
  end

  // Refresh demand bookkeeping. A wrap coinciding with REF cancels out.
  always_ff @(posedge core_clk or posedge core_rst_sync) begin
    if (core_rst_sync) begin
      r_timer    <= '0;
      r_ref_pend <= '0;
      r_ovf      <= 1'b0;
    end else begin
      if (r_state == INIT_PASS || w_wrap) r_timer <= '0;
      else                                r_timer <= r_timer + TW'(1);

      if (w_wrap && !w_dec) begin
        if (w_force) r_ovf      <= 1'b1;
        else         r_ref_pend <= r_ref_pend + PW'(1);
      end else if (w_dec && !w_wrap) begin
        r_ref_pend <= r_ref_pend - PW'(1);
      end
    end
  end

  assign usr_ack      = w_ack;
  assign ref_busy     = (r_state == PREA) || (r_state == PREA_WAIT) ||
                        (r_state == REF)  || (r_state == REF_WAIT);
  assign ref_overflow = r_ovf;
  assign ddr_cs_n     = r_cmd.cs_n;
  assign ddr_ras_n    = r_cmd.ras_n;
  assign ddr_cas_n    = r_cmd.cas_n;
  assign ddr_we_n     = r_cmd.we_n;
  assign ddr_ba       = r_cmd.ba;
  assign ddr_a        = r_cmd.a;

endmodule

// File: tb/tb_ddr_cmd_arb.sv
// Directed bench for ddr_cmd_arb. Expected DDR commands are queued as each
// cycle's stimulus is driven and popped one cycle later when the registered
// outputs appear. A second instance with a short refresh interval and no user
// traffic falls behind on refresh and is used to observe ref_overflow.
module tb_ddr_cmd_arb;
  localparam int BA = 2;
  localparam int RW = 13;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  typedef struct packed {
    logic [3:0]    c;
    logic [BA-1:0] ba;
    logic [RW-1:0] a;
  } exp_t;

  logic          core_clk = 1'b0;
  logic          core_rst_sync = 1'b0;
  logic          init_done = 1'b0;
  logic          init_cs_n = 1'b1, init_ras_n = 1'b1, init_cas_n = 1'b1, init_we_n = 1'b1;
  logic [BA-1:0] init_ba = '0;
  logic [RW-1:0] init_a = '0;
  logic          usr_req = 1'b0;
  logic          usr_ras_n = 1'b1, usr_cas_n = 1'b1, usr_we_n = 1'b1;
  logic [BA-1:0] usr_ba = '0;
  logic [RW-1:0] usr_a = '0;

  logic          usr_ack, ref_busy, ref_overflow;
  logic          ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n;
  logic [BA-1:0] ddr_ba;
  logic [RW-1:0] ddr_a;

  logic          s_usr_ack, s_ref_busy, s_ref_overflow;
  logic          s_cs_n, s_ras_n, s_cas_n, s_we_n;
  logic [BA-1:0] s_ba;
  logic [RW-1:0] s_a;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 core_clk = ~core_clk;

  ddr_cmd_arb #(.BA_BITS(BA), .ROW_BITS(RW), .TREFI_CYC(20), .TRP_CYC(3),
                .TRFC_CYC(10), .MAX_PEND(8)) dut (
    .core_clk(core_clk), .core_rst_sync(core_rst_sync), .init_done(init_done),
    .init_cs_n(init_cs_n), .init_ras_n(init_ras_n), .init_cas_n(init_cas_n),
    .init_we_n(init_we_n), .init_ba(init_ba), .init_a(init_a),
    .usr_req(usr_req), .usr_ras_n(usr_ras_n), .usr_cas_n(usr_cas_n),
    .usr_we_n(usr_we_n), .usr_ba(usr_ba), .usr_a(usr_a),
    .usr_ack(usr_ack), .ref_busy(ref_busy), .ref_overflow(ref_overflow),
    .ddr_cs_n(ddr_cs_n), .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n),
    .ddr_we_n(ddr_we_n), .ddr_ba(ddr_ba), .ddr_a(ddr_a));

  ddr_cmd_arb #(.BA_BITS(BA), .ROW_BITS(RW), .TREFI_CYC(6), .TRP_CYC(3),
                .TRFC_CYC(10), .MAX_PEND(8)) dut_sat (
    .core_clk(core_clk), .core_rst_sync(core_rst_sync), .init_done(init_done),
    .init_cs_n(init_cs_n), .init_ras_n(init_ras_n), .init_cas_n(init_cas_n),
    .init_we_n(init_we_n), .init_ba(init_ba), .init_a(init_a),
    .usr_req(1'b0), .usr_ras_n(usr_ras_n), .usr_cas_n(usr_cas_n),
    .usr_we_n(usr_we_n), .usr_ba(usr_ba), .usr_a(usr_a),
    .usr_ack(s_usr_ack), .ref_busy(s_ref_busy), .ref_overflow(s_ref_overflow),
    .ddr_cs_n(s_cs_n), .ddr_ras_n(s_ras_n), .ddr_cas_n(s_cas_n),
    .ddr_we_n(s_we_n), .ddr_ba(s_ba), .ddr_a(s_a));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] c, input logic [BA-1:0] ba,
                              input logic [RW-1:0] a);
    exp_t e;
    e.c = c; e.ba = ba; e.a = a;
    return e;
  endfunction

  // Advance one clock and score the registered outputs against the queue.
  task automatic tick();
    exp_t e;
    @(posedge core_clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("ddr_cmd", {28'd0, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}, {28'd0, e.c});
      chk("ddr_ba", {30'd0, ddr_ba}, {30'd0, e.ba});
      chk("ddr_a", {19'd0, ddr_a}, {19'd0, e.a});
    end
  endtask

  // Inputs for this cycle are already driven: check combinational outputs,
  // queue the command expected after the edge, then clock.
  task automatic cyc(input string tag, input logic ack_e, input logic busy_e, input exp_t nxt);
    #1;
    chk({tag, "_ack"}, {31'd0, usr_ack}, {31'd0, ack_e});
    chk({tag, "_busy"}, {31'd0, ref_busy}, {31'd0, busy_e});
    sb.push_back(nxt);
    tick();
  endtask

  task automatic set_init(input logic [3:0] c, input logic [BA-1:0] ba, input logic [RW-1:0] a);
    {init_cs_n, init_ras_n, init_cas_n, init_we_n} = c;
    init_ba = ba;
    init_a  = a;
  endtask

  task automatic set_usr(input logic [2:0] c, input logic [BA-1:0] ba, input logic [RW-1:0] a);
    {usr_ras_n, usr_cas_n, usr_we_n} = c;
    usr_ba = ba;
    usr_a  = a;
  endtask

  initial begin
    logic [2:0]    uc;
    logic [BA-1:0] ub;
    logic [RW-1:0] ua;

    // ---- reset values
    #1 core_rst_sync = 1'b1;
    #1;
    chk("rst_cmd", {28'd0, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}, 32'hF);
    chk("rst_ba", {30'd0, ddr_ba}, 32'd0);
    chk("rst_a", {19'd0, ddr_a}, 32'd0);
    chk("rst_ack", {31'd0, usr_ack}, 32'd0);
    chk("rst_busy", {31'd0, ref_busy}, 32'd0);
    chk("rst_ovf", {31'd0, ref_overflow}, 32'd0);
    chk("sat_rst_out", {13'd0, s_usr_ack, s_ref_busy, s_ref_overflow, s_cs_n, s_ras_n,
                        s_cas_n, s_we_n, s_ba, s_a}, {13'd0, 3'b000, 4'hF, 2'd0, 13'd0});
    repeat (2) @(posedge core_clk);
    #1 core_rst_sync = 1'b0;

    // ---- init pass-through; user request must be ignored
    set_usr(3'b011, 2'd2, 13'h123);
    usr_req = 1'b1;
    set_init(C_PRE, 2'd0, 13'h400);
    cyc("init_pre", 1'b0, 1'b0, mk(C_PRE, 2'd0, 13'h400));
    set_init(4'b0000, 2'd1, 13'h032);
    cyc("init_mrs", 1'b0, 1'b0, mk(4'b0000, 2'd1, 13'h032));
    set_init(C_NOP, 2'd3, 13'h1FFF);
    cyc("init_nop", 1'b0, 1'b0, mk(C_NOP, 2'd3, 13'h1FFF));
    // init_done cycle still forwards its init sample
    set_init(C_NOP, 2'd2, 13'h0AA);
    init_done = 1'b1;
    cyc("init_done", 1'b0, 1'b0, mk(C_NOP, 2'd2, 13'h0AA));

    // ---- idle refresh: cycles 1..21 NOP, init bus no longer forwarded
    init_done = 1'b0;
    set_init(4'b0000, 2'd3, 13'h1555);
    usr_req = 1'b0;
    chk("timer_start", {{(32-$bits(dut.r_timer)){1'b0}}, dut.r_timer}, 32'd0);
    for (int i = 0; i < 21; i++) cyc("idle", 1'b0, 1'b0, mk(C_NOP, 2'd0, 13'd0));
    chk("pend_one", {28'd0, dut.r_ref_pend}, 32'd1);
    cyc("prea", 1'b0, 1'b1, mk(C_PRE, 2'd0, 13'h400));
    for (int i = 0; i < 3; i++) cyc("trp", 1'b0, 1'b1, mk(C_NOP, 2'd0, 13'd0));
    cyc("ref", 1'b0, 1'b1, mk(C_REF, 2'd0, 13'd0));
    for (int i = 0; i < 10; i++) cyc("trfc", 1'b0, 1'b1, mk(C_NOP, 2'd0, 13'd0));
    chk("pend_zero", {28'd0, dut.r_ref_pend}, 32'd0);

    // ---- user traffic across 8 timer wraps (cycles 37..180)
    usr_req = 1'b1;
    for (int i = 0; i < 144; i++) begin
      if (i < 8) begin
        uc = 3'b011; ub = 2'd2; ua = 13'h123;
      end else begin
        uc = (i % 3 == 0) ? 3'b011 : (i % 3 == 1) ? 3'b100 : 3'b101;
        ub = BA'(i);
        ua = RW'(i * 37);
      end
      set_usr(uc, ub, ua);
      cyc("usr", 1'b1, 1'b0, mk({1'b0, uc}, ub, ua));
    end
    chk("pend_sat", {28'd0, dut.r_ref_pend}, 32'd8);
    chk("sat_ovf_set", {31'd0, s_ref_overflow}, 32'd1);

    // ---- forced refresh despite usr_req
    set_usr(3'b100, 2'd1, 13'h0F0);
    cyc("force", 1'b0, 1'b0, mk(C_NOP, 2'd0, 13'd0));
    cyc("f_prea", 1'b0, 1'b1, mk(C_PRE, 2'd0, 13'h400));
    for (int i = 0; i < 3; i++) cyc("f_trp", 1'b0, 1'b1, mk(C_NOP, 2'd0, 13'd0));
    cyc("f_ref", 1'b0, 1'b1, mk(C_REF, 2'd0, 13'd0));
    for (int i = 0; i < 10; i++) cyc("f_trfc", 1'b0, 1'b1, mk(C_NOP, 2'd0, 13'd0));
    chk("pend_seven", {28'd0, dut.r_ref_pend}, 32'd7);
    for (int i = 0; i < 4; i++) cyc("resume", 1'b1, 1'b0, mk(4'b0100, 2'd1, 13'h0F0));
    // wrap at the end of that run pushes pend back to 8 -> forced again
    cyc("force2", 1'b0, 1'b0, mk(C_NOP, 2'd0, 13'd0));
    cyc("f2_prea", 1'b0, 1'b1, mk(C_PRE, 2'd0, 13'h400));
    for (int i = 0; i < 3; i++) cyc("f2_trp", 1'b0, 1'b1, mk(C_NOP, 2'd0, 13'd0));
    cyc("f2_ref", 1'b0, 1'b1, mk(C_REF, 2'd0, 13'd0));
    for (int i = 0; i < 2; i++) cyc("f2_trfc", 1'b0, 1'b1, mk(C_NOP, 2'd0, 13'd0));
    chk("ovf_clear_main", {31'd0, ref_overflow}, 32'd0);
    chk("sat_ovf_sticky", {31'd0, s_ref_overflow}, 32'd1);
    chk("busy_refwait", {31'd0, ref_busy}, 32'd1);

    // ---- asynchronous reset in the middle of REF_WAIT
    core_rst_sync = 1'b1;
    #1;
    chk("mrst_cmd", {28'd0, ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n}, 32'hF);
    chk("mrst_ba_a", {17'd0, ddr_ba, ddr_a}, 32'd0);
    chk("mrst_busy", {31'd0, ref_busy}, 32'd0);
    chk("mrst_ack", {31'd0, usr_ack}, 32'd0);
    chk("mrst_pend", {28'd0, dut.r_ref_pend}, 32'd0);
    chk("mrst_timer", {{(32-$bits(dut.r_timer)){1'b0}}, dut.r_timer}, 32'd0);
    chk("mrst_sat_ovf", {31'd0, s_ref_overflow}, 32'd0);
    sb.delete();
    @(posedge core_clk);
    #1 core_rst_sync = 1'b0;

    // ---- back in INIT_PASS
    set_init(C_PRE, 2'd0, 13'h400);
    cyc("post_rst", 1'b0, 1'b0, mk(C_PRE, 2'd0, 13'h400));
    set_init(4'b0000, 2'd3, 13'h0AB);
    cyc("post_rst2", 1'b0, 1'b0, mk(4'b0000, 2'd3, 13'h0AB));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
